pipe_hazard_unit: RTL and testbench
===================================

PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

Interface
REQ-001 The block SHALL have parameter REG_AW, default 5, meaning the register-address width (2**REG_AW registers; register 0 hard-wired zero).
REQ-002 The block SHALL have parameter MD_LAT, default 4, legal 2..15, meaning the cycles a multiply/divide occupies the MD unit.
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning the stall-counter width.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset: Clk  in  1  clock (all state on rising edge); Clrn  in  1  synchronous active-high reset.
REQ-005 The block SHALL have these decode inputs: D_Rs, D_Rt  in  REG_AW  ID sources; D_UseRs, D_UseRt  in  1  source read; D_IsMd  in  1  ID holds MD start; D_UseHiLo  in  1  ID reads MD result.
REQ-006 The block SHALL have these pipeline inputs: E_Rd, M_Rd  in  REG_AW  destinations; E_Wreg, M_Wreg  in  1  writes reg; E_Reg2reg, M_Reg2reg  in  1  load (result from memory); M_Taken  in  1  branch/jump in MEM taken.
REQ-007 The block SHALL have these outputs: FwdA, FwdB  out  2  operand select; we_irid  out  1  PC and IF/ID write enable; Bubble  out  1  load NOP into ID/EXE; FlushID  out  1  clear IF/ID; Md_Busy  out  1  MD occupied; Md_Done  out  1  MD result ready pulse; StallCnt  out  CNT_W  stall-cycle count.

Function
REQ-008 Fwd encoding SHALL be: 00 register file, 01 E_ALUR, 10 M_ALUR, 11 M_Dout.
REQ-009 FwdA SHALL be 01 if D_UseRs and E_Wreg and not E_Reg2reg and E_Rd==D_Rs!=0; else 10 if M_Wreg and not M_Reg2reg and M_Rd==D_Rs!=0; else 11 if M_Wreg and M_Reg2reg and M_Rd==D_Rs!=0; else 00. FwdB SHALL be identical using D_Rt/D_UseRt.
REQ-010 EXE match SHALL take priority over MEM match; WB results SHALL NOT be forwarded (register file writes before read), giving 00.
REQ-011 Load-use hazard (E_Wreg, E_Reg2reg, E_Rd!=0, E_Rd equals a used source) SHALL give we_irid=0, Bubble=1 for exactly one cycle.
REQ-012 MD FSM states SHALL be IDLE, BUSY, DONE; reset state IDLE.
REQ-013 IDLE->BUSY when D_IsMd, we_irid=1 and M_Taken=0; counter loads MD_LAT-1.
REQ-014 BUSY SHALL decrement each cycle; at counter 1 go DONE; DONE lasts one cycle with Md_Done=1, then IDLE.
REQ-015 Md_Busy SHALL be 1 in BUSY and DONE.
REQ-016 In BUSY or DONE, D_IsMd or D_UseHiLo SHALL give we_irid=0, Bubble=1; in DONE with D_UseHiLo the stall SHALL release the next cycle (IDLE).
REQ-017 M_Taken=1 SHALL override all stalls: we_irid=1, Bubble=1, FlushID=1 that cycle, no MD start.
REQ-018 M_Taken SHALL NOT abort an MD operation already in BUSY/DONE.
REQ-019 Default (no hazard): we_irid=1, Bubble=0, FlushID=0.
REQ-020 StallCnt SHALL increment on every cycle with we_irid=0 and saturate at all-ones.
REQ-021 Fwd, we_irid, Bubble, FlushID SHALL be combinational (same cycle); Md_Busy, Md_Done, StallCnt SHALL be registered state.

Reset
REQ-022 Clrn=1 at a rising edge SHALL force IDLE, counter 0, StallCnt 0, Md_Busy 0, Md_Done 0, including mid-operation in BUSY.
REQ-023 During reset, combinational outputs SHALL follow REQ-009..REQ-019 from current inputs with FSM state IDLE.

Structure
REQ-024 Fwd encodings (00/01/10/11) and MD state encodings SHALL live in the shared CPU package/include file.
REQ-025 Operand forwarding compare SHALL be one sub-module, pipe_fwd_sel, instantiated twice (A and B).

Verification
REQ-026 E: Wreg=1, Reg2reg=0, Rd=5; D_Rs=5, UseRs=1 -> FwdA=01, we_irid=1, Bubble=0.
REQ-027 E load Rd=7, D_Rt=7 UseRt=1 -> one cycle we_irid=0, Bubble=1, StallCnt+1; next cycle (load in M) FwdB=11.
REQ-028 E_Rd=M_Rd=3 both ALU writes, D_Rs=3 -> FwdA=01; D_Rs=0 with E_Rd=0 -> FwdA=00.
REQ-029 MD_LAT=4: D_IsMd at cycle 0 -> Md_Busy 1 cycles 1..4, Md_Done=1 at cycle 4 only; D_UseHiLo held -> we_irid=0 cycles 1..4, 1 at cycle 5.
REQ-030 Load-use hazard and M_Taken=1 same cycle -> we_irid=1, Bubble=1, FlushID=1, StallCnt unchanged.
REQ-031 Clrn=1 in BUSY -> next cycle Md_Busy=0, StallCnt=0; CNT_W=2 with 5 stall cycles -> StallCnt=3.

Source files
------------

// File: rtl/pipe_hazard_pkg.sv
// Shared encodings for the pipeline hazard logic: operand-forward selects
// and multiply/divide unit states.
package pipe_hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXE   = 2'b01,
    FWD_MEM   = 2'b10,
    FWD_MDOUT = 2'b11
  } fwd_sel_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_BUSY = 2'b01,
    MD_DONE = 2'b10
  } md_state_e;

  // Wide enough for the largest legal MD latency (15).
  localparam int MD_CNT_W = 4;

endpackage

// File: rtl/pipe_fwd_sel.sv
// Forwarding select for one ID source operand; also flags a load-use hit
// against the instruction currently in EXE.
module pipe_fwd_sel
  import pipe_hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] i_src,
  input  logic              i_use,
  input  logic [REG_AW-1:0] i_e_rd,
  input  logic              i_e_wreg,
  input  logic              i_e_reg2reg,
  input  logic [REG_AW-1:0] i_m_rd,
  input  logic              i_m_wreg,
  input  logic              i_m_reg2reg,
  output fwd_sel_e          o_fwd,
  output logic              o_load_use
);

  logic w_live;
  logic w_e_hit;
  logic w_m_hit;

  // Register 0 is hard-wired zero, so it never needs a bypass.
  assign w_live  = i_use && (i_src != '0);
  assign w_e_hit = w_live && i_e_wreg && (i_e_rd == i_src);
  assign w_m_hit = w_live && i_m_wreg && (i_m_rd == i_src);

  assign o_load_use = w_e_hit && i_e_reg2reg;

  always_comb begin
    // NOTE: default first so every path assigns o_fwd and no latch is inferred.
    o_fwd = FWD_RF;
    if (w_e_hit && !i_e_reg2reg)     o_fwd = FWD_EXE;
    else if (w_m_hit && !i_m_reg2reg) o_fwd = FWD_MEM;
    else if (w_m_hit && i_m_reg2reg)  o_fwd = FWD_MDOUT;
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard unit: operand forwarding, load-use and multiply/divide stalls,
// taken-branch flush, and a saturating stall-cycle counter.
module pipe_hazard_unit
  import pipe_hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Clrn,
  input  logic [REG_AW-1:0] D_Rs,
  input  logic [REG_AW-1:0] D_Rt,
  input  logic              D_UseRs,
  input  logic              D_UseRt,
  input  logic              D_IsMd,
  input  logic              D_UseHiLo,
  input  logic [REG_AW-1:0] E_Rd,
  input  logic [REG_AW-1:0] M_Rd,
  input  logic              E_Wreg,
  input  logic              M_Wreg,
  input  logic              E_Reg2reg,
  input  logic              M_Reg2reg,
  input  logic              M_Taken,
  output logic [1:0]        FwdA,
  output logic [1:0]        FwdB,
  output logic              we_irid,
  output logic              Bubble,
  output logic              FlushID,
  output logic              Md_Busy,
  output logic              Md_Done,
  output logic [CNT_W-1:0]  StallCnt
);

  md_state_e           r_state;
  logic [MD_CNT_W-1:0] r_md_cnt;
  logic                r_md_busy;
  logic                r_md_done;
  logic [CNT_W-1:0]    r_stall_cnt;

  fwd_sel_e  w_fwd_a;
  fwd_sel_e  w_fwd_b;
  logic      w_ld_use_a;
  logic      w_ld_use_b;
  md_state_e w_state;
  logic      w_md_stall;
  logic      w_md_start;

  pipe_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .i_src       (D_Rs),
    .i_use       (D_UseRs),
    .i_e_rd      (E_Rd),
    .i_e_wreg    (E_Wreg),
    .i_e_reg2reg (E_Reg2reg),
    .i_m_rd      (M_Rd),
    .i_m_wreg    (M_Wreg),
    .i_m_reg2reg (M_Reg2reg),
    .o_fwd       (w_fwd_a),
    .o_load_use  (w_ld_use_a)
  );

  pipe_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .i_src       (D_Rt),
    .i_use       (D_UseRt),
    .i_e_rd      (E_Rd),
    .i_e_wreg    (E_Wreg),
    .i_e_reg2reg (E_Reg2reg),
    .i_m_rd      (M_Rd),
    .i_m_wreg    (M_Wreg),
    .i_m_reg2reg (M_Reg2reg),
    .o_fwd       (w_fwd_b),
    .o_load_use  (w_ld_use_b)
  );

  assign FwdA = w_fwd_a;
  assign FwdB = w_fwd_b;

  // While reset is asserted the stall logic sees the unit as idle.
  assign w_state    = Clrn ? MD_IDLE : r_state;
  assign w_md_stall = (w_state != MD_IDLE) && (D_IsMd || D_UseHiLo);

  always_comb begin
    we_irid = 1'b1;
    Bubble  = 1'b0;
    FlushID = 1'b0;
    if (M_Taken) begin
      Bubble  = 1'b1;
      FlushID = 1'b1;
    end else if (w_ld_use_a || w_ld_use_b || w_md_stall) begin
      we_irid = 1'b0;
      Bubble  = 1'b1;
    end
  end

  assign w_md_start = (w_state == MD_IDLE) && D_IsMd && we_irid && !M_Taken;

  // NOTE: synchronous reset lives inside the clocked block; all state uses <=.
  always_ff @(posedge Clk) begin
    if (Clrn) begin
      r_state     <= MD_IDLE;
      r_md_cnt    <= '0;
      r_md_busy   <= 1'b0;
      r_md_done   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      if (!we_irid && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);

      case (r_state)
        MD_IDLE: begin
          if (w_md_start) begin
            r_state   <= MD_BUSY;
            r_md_cnt  <= MD_CNT_W'(MD_LAT - 1);
            r_md_busy <= 1'b1;
          end
        end
        MD_BUSY: begin
          r_md_cnt <= r_md_cnt - MD_CNT_W'(1);
          if (r_md_cnt == MD_CNT_W'(1)) begin
            r_state   <= MD_DONE;
            r_md_done <= 1'b1;
          end
        end
        MD_DONE: begin
          r_state   <= MD_IDLE;
          r_md_busy <= 1'b0;
          r_md_done <= 1'b0;
        end
        default: begin
          r_state   <= MD_IDLE;
          r_md_busy <= 1'b0;
          r_md_done <= 1'b0;
        end
      endcase
    end
  end

  assign Md_Busy  = r_md_busy;
  assign Md_Done  = r_md_done;
  assign StallCnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench for pipe_hazard_unit: expected outputs are queued as each
// step is driven and compared when the outputs are sampled mid-cycle.
module tb_pipe_hazard_unit;

  typedef struct {
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        we;
    logic        bub;
    logic        fl;
    logic        busy;
    logic        done;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } exp_t;

  logic       Clk = 1'b0;
  logic       Clrn;
  logic [4:0] D_Rs, D_Rt, E_Rd, M_Rd;
  logic       D_UseRs, D_UseRt, D_IsMd, D_UseHiLo;
  logic       E_Wreg, M_Wreg, E_Reg2reg, M_Reg2reg, M_Taken;

  logic [1:0]  FwdA, FwdB, FwdA2, FwdB2;
  logic        we_irid, Bubble, FlushID, Md_Busy, Md_Done;
  logic        we_irid2, Bubble2, FlushID2, Md_Busy2, Md_Done2;
  logic [15:0] StallCnt;
  logic [1:0]  StallCnt2;

  exp_t        sb_q[$];
  logic [15:0] exp_cnt;
  logic [1:0]  exp_cnt2;
  int          n_checks = 0;
  int          n_errors = 0;
  int          step_no  = 0;

  always #5 Clk = ~Clk;

  pipe_hazard_unit dut (
    .Clk(Clk), .Clrn(Clrn), .D_Rs(D_Rs), .D_Rt(D_Rt),
    .D_UseRs(D_UseRs), .D_UseRt(D_UseRt), .D_IsMd(D_IsMd), .D_UseHiLo(D_UseHiLo),
    .E_Rd(E_Rd), .M_Rd(M_Rd), .E_Wreg(E_Wreg), .M_Wreg(M_Wreg),
    .E_Reg2reg(E_Reg2reg), .M_Reg2reg(M_Reg2reg), .M_Taken(M_Taken),
    .FwdA(FwdA), .FwdB(FwdB), .we_irid(we_irid), .Bubble(Bubble),
    .FlushID(FlushID), .Md_Busy(Md_Busy), .Md_Done(Md_Done), .StallCnt(StallCnt)
  );

  // Narrow-counter instance, used only for its saturation behaviour.
  pipe_hazard_unit #(.CNT_W(2)) dut_sat (
    .Clk(Clk), .Clrn(Clrn), .D_Rs(D_Rs), .D_Rt(D_Rt),
    .D_UseRs(D_UseRs), .D_UseRt(D_UseRt), .D_IsMd(D_IsMd), .D_UseHiLo(D_UseHiLo),
    .E_Rd(E_Rd), .M_Rd(M_Rd), .E_Wreg(E_Wreg), .M_Wreg(M_Wreg),
    .E_Reg2reg(E_Reg2reg), .M_Reg2reg(M_Reg2reg), .M_Taken(M_Taken),
    .FwdA(FwdA2), .FwdB(FwdB2), .we_irid(we_irid2), .Bubble(Bubble2),
    .FlushID(FlushID2), .Md_Busy(Md_Busy2), .Md_Done(Md_Done2), .StallCnt(StallCnt2)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s step=%0d observed=%h expected=%h", tag, step_no, obs, exp);
    end
  endtask

  task automatic clear_in();
    D_Rs = '0; D_Rt = '0; E_Rd = '0; M_Rd = '0;
    D_UseRs = 0; D_UseRt = 0; D_IsMd = 0; D_UseHiLo = 0;
    E_Wreg = 0; M_Wreg = 0; E_Reg2reg = 0; M_Reg2reg = 0; M_Taken = 0;
  endtask

  task automatic step(input logic [1:0] fa, input logic [1:0] fb, input logic we,
                      input logic bub, input logic fl, input logic busy, input logic done);
    exp_t e, g;
    e.fa = fa; e.fb = fb; e.we = we; e.bub = bub; e.fl = fl;
    e.busy = busy; e.done = done; e.cnt = exp_cnt; e.cnt2 = exp_cnt2;
    sb_q.push_back(e);
    @(negedge Clk);
    g = sb_q.pop_front();
    check("fwd_a",     16'(FwdA),      16'(g.fa));
    check("fwd_b",     16'(FwdB),      16'(g.fb));
    check("we_irid",   16'(we_irid),   16'(g.we));
    check("bubble",    16'(Bubble),    16'(g.bub));
    check("flush_id",  16'(FlushID),   16'(g.fl));
    check("md_busy",   16'(Md_Busy),   16'(g.busy));
    check("md_done",   16'(Md_Done),   16'(g.done));
    check("stall_cnt", StallCnt,       g.cnt);
    check("stall_sat", 16'(StallCnt2), 16'(g.cnt2));
    if (Clrn) begin
      exp_cnt  = '0;
      exp_cnt2 = '0;
    end else if (!g.we) begin
      if (exp_cnt  != 16'hffff) exp_cnt++;
      if (exp_cnt2 != 2'b11)    exp_cnt2++;
    end
    @(posedge Clk); #1;
    step_no++;
  endtask

  initial begin
    exp_cnt = '0; exp_cnt2 = '0;
    clear_in();
    Clrn = 1;
    @(posedge Clk); #1;
    step(2'b00, 2'b00, 1, 0, 0, 0, 0);              // reset state
    Clrn = 0;

    // EXE ALU result forwarded to Rs
    clear_in(); E_Wreg = 1; E_Rd = 5; D_Rs = 5; D_UseRs = 1;
    step(2'b01, 2'b00, 1, 0, 0, 0, 0);

    // EXE and MEM both write r3: EXE wins for both operands
    clear_in(); E_Wreg = 1; E_Rd = 3; M_Wreg = 1; M_Rd = 3;
    D_Rs = 3; D_UseRs = 1; D_Rt = 3; D_UseRt = 1;
    step(2'b01, 2'b01, 1, 0, 0, 0, 0);

    // r0 never forwarded
    clear_in(); E_Wreg = 1; M_Wreg = 1; D_UseRs = 1; D_UseRt = 1;
    step(2'b00, 2'b00, 1, 0, 0, 0, 0);

    // MEM ALU result forwarded
    clear_in(); M_Wreg = 1; M_Rd = 9; D_Rs = 9; D_UseRs = 1; D_Rt = 9; D_UseRt = 1;
    step(2'b10, 2'b10, 1, 0, 0, 0, 0);

    // load in EXE feeding Rt: one stall cycle
    clear_in(); E_Wreg = 1; E_Reg2reg = 1; E_Rd = 7; D_Rt = 7; D_UseRt = 1;
    step(2'b00, 2'b00, 0, 1, 0, 0, 0);
    // load now in MEM: memory data forwarded
    clear_in(); M_Wreg = 1; M_Reg2reg = 1; M_Rd = 7; D_Rt = 7; D_UseRt = 1;
    step(2'b00, 2'b11, 1, 0, 0, 0, 0);

    // matching load but source not read: no stall
    clear_in(); E_Wreg = 1; E_Reg2reg = 1; E_Rd = 4; D_Rs = 4;
    step(2'b00, 2'b00, 1, 0, 0, 0, 0);

    // load-use together with taken branch: flush wins, no stall counted
    clear_in(); E_Wreg = 1; E_Reg2reg = 1; E_Rd = 4; D_Rs = 4; D_UseRs = 1; M_Taken = 1;
    step(2'b00, 2'b00, 1, 1, 1, 0, 0);

    // MD op, then HI/LO reader held until result ready
    clear_in(); D_IsMd = 1;
    step(2'b00, 2'b00, 1, 0, 0, 0, 0);              // cycle 0
    clear_in(); D_UseHiLo = 1;
    step(2'b00, 2'b00, 0, 1, 0, 1, 0);              // cycle 1
    step(2'b00, 2'b00, 0, 1, 0, 1, 0);              // cycle 2
    step(2'b00, 2'b00, 0, 1, 0, 1, 0);              // cycle 3
    step(2'b00, 2'b00, 0, 1, 0, 1, 1);              // cycle 4
    step(2'b00, 2'b00, 1, 0, 0, 0, 0);              // cycle 5

    // MD start blocked by a taken branch
    clear_in(); D_IsMd = 1; M_Taken = 1;
    step(2'b00, 2'b00, 1, 1, 1, 0, 0);
    clear_in();
    step(2'b00, 2'b00, 1, 0, 0, 0, 0);

    // MD op not aborted by a branch, then reset while busy
    clear_in(); D_IsMd = 1;
    step(2'b00, 2'b00, 1, 0, 0, 0, 0);
    clear_in(); M_Taken = 1;
    step(2'b00, 2'b00, 1, 1, 1, 1, 0);
    clear_in(); D_UseHiLo = 1; Clrn = 1;
    step(2'b00, 2'b00, 1, 0, 0, 1, 0);
    Clrn = 0; clear_in();
    step(2'b00, 2'b00, 1, 0, 0, 0, 0);

    // five load-use stalls: narrow counter saturates at 3
    clear_in(); E_Wreg = 1; E_Reg2reg = 1; E_Rd = 7; D_Rt = 7; D_UseRt = 1;
    for (int i = 0; i < 5; i++) step(2'b00, 2'b00, 0, 1, 0, 0, 0);
    clear_in();
    step(2'b00, 2'b00, 1, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
